// File: rtl/dspl_pkg.sv
// Shared seven-segment display definitions.
// Digit field layout and active-low a..g segment patterns.
package dspl_pkg;

  localparam int DIGIT_W = 6;
  localparam int EN_BIT  = 5;
  localparam int HEX_MSB = 4;
  localparam int HEX_LSB = 1;
  localparam int DP_BIT  = 0;

  typedef struct packed {
    logic       en;
    logic [3:0] hex;
    logic       dp;
  } dig_fld_t;

  // Index 0 is the rightmost entry; bit 6 = segment a.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  function automatic logic [6:0] seg_pat(
    input logic [3:0] h
  );
    return SEG_LUT[h];
  endfunction

endpackage

// File: rtl/dspl_mux_drv_seg7_hex_dec.sv
// Combinational hex + dp to active-low cathode decoder.
// Output bits [7:1] = segments a..g, bit 0 = dp.
module seg7_hex_dec
  import dspl_pkg::*;
(
  input  logic [3:0] hex_i,
  input  logic       dp_i,
  output logic [7:0] cat_o
);

  assign cat_o = {seg_pat(hex_i), ~dp_i};

endmodule

// File: rtl/dspl_mux_drv.sv
// Multiplexed common-anode seven-segment driver with
// per-digit blink, 16-level PWM dimming and blanking.
module dspl_mux_drv
  import dspl_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int DIG_PERIOD   = 100000,
  parameter int BLANK_CYCLES = 4,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DIGIT_W*N_DIGITS-1:0]   digits,
  input  logic [N_DIGITS-1:0]           blink_mask,
  input  logic [3:0]                    brightness,
  output logic [N_DIGITS-1:0]           an,
  output logic [7:0]                    dec_cat,
  output logic                          frame_start
);

  localparam int SLOT_W = $clog2(DIG_PERIOD);
  localparam int IDX_W =
    (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FRM_W =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST =
    SLOT_W'(DIG_PERIOD - 1);
  localparam logic [SLOT_W-1:0] BLANK_V =
    SLOT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(N_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST =
    FRM_W'(BLINK_FRAMES - 1);

  logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]    dig_idx_q, dig_idx_d;
  logic [FRM_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                blink_ph_q, blink_ph_d;
  logic [3:0]          bright_q, bright_d;
  dig_fld_t            cur_dig_q, cur_dig_d;
  logic                cur_blink_q, cur_blink_d;
  logic [3:0]          pwm_cnt_q, pwm_cnt_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [7:0]          cat_q, cat_d;
  logic                fs_q, fs_d;

  logic     slot_start;
  logic     slot_end;
  logic     frame_end;
  dig_fld_t live_dig;
  logic     live_blink;
  dig_fld_t sel_dig;
  logic     sel_blink;
  logic     dig_on;
  logic [7:0] dec_raw;

  assign slot_start = (slot_cnt_q == '0);
  assign slot_end   = (slot_cnt_q == SLOT_LAST);
  assign frame_end  = slot_end & (dig_idx_q == IDX_LAST);

  always_comb begin
    live_dig   = '0;
    live_blink = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (dig_idx_q == IDX_W'(i)) begin
        live_dig   = digits[i*DIGIT_W +: DIGIT_W];
        live_blink = blink_mask[i];
      end
    end
  end

  // The slot-start cycle uses the live field so the
  // first slot after reset is already valid.
  assign sel_dig   = slot_start ? live_dig : cur_dig_q;
  assign sel_blink = slot_start ? live_blink : cur_blink_q;

  assign dig_on = sel_dig.en
                & ~(sel_blink & blink_ph_q)
                & (slot_cnt_q >= BLANK_V)
                & (pwm_cnt_q <= bright_q);

  seg7_hex_dec u_dec (
    .hex_i (sel_dig.hex),
    .dp_i  (sel_dig.dp),
    .cat_o (dec_raw)
  );

  always_comb begin
    slot_cnt_d  = slot_cnt_q + SLOT_W'(1);
    dig_idx_d   = dig_idx_q;
    frame_cnt_d = frame_cnt_q;
    blink_ph_d  = blink_ph_q;
    bright_d    = bright_q;
    cur_dig_d   = cur_dig_q;
    cur_blink_d = cur_blink_q;
    pwm_cnt_d   = pwm_cnt_q + 4'd1;
    an_d        = '1;
    cat_d       = 8'hFF;
    fs_d        = slot_start & (dig_idx_q == '0);

    if (slot_end) begin
      slot_cnt_d = '0;
      pwm_cnt_d  = '0;
      if (dig_idx_q == IDX_LAST) begin
        dig_idx_d = '0;
      end else begin
        dig_idx_d = dig_idx_q + IDX_W'(1);
      end
    end

    if (frame_end) begin
      bright_d = brightness;
      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FRM_W'(1);
      end
    end

    if (slot_start) begin
      cur_dig_d   = live_dig;
      cur_blink_d = live_blink;
    end

    if (dig_on) begin
      cat_d = dec_raw;
      for (int i = 0; i < N_DIGITS; i++) begin
        if (dig_idx_q == IDX_W'(i)) begin
          an_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_cnt_q  <= '0;
      dig_idx_q   <= '0;
      frame_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      bright_q    <= 4'hF;
      cur_dig_q   <= '0;
      cur_blink_q <= 1'b0;
      pwm_cnt_q   <= '0;
      an_q        <= '1;
      cat_q       <= 8'hFF;
      fs_q        <= 1'b0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      dig_idx_q   <= dig_idx_d;
      frame_cnt_q <= frame_cnt_d;
      blink_ph_q  <= blink_ph_d;
      bright_q    <= bright_d;
      cur_dig_q   <= cur_dig_d;
      cur_blink_q <= cur_blink_d;
      pwm_cnt_q   <= pwm_cnt_d;
      an_q        <= an_d;
      cat_q       <= cat_d;
      fs_q        <= fs_d;
    end
  end

  assign an          = an_q;
  assign dec_cat     = cat_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_dspl_mux_drv.sv
// Scoreboard bench for dspl_mux_drv (4 digits, plus a
// 1-digit instance), with directed frame-level checks.
module tb_dspl_mux_drv;

  localparam int N  = 4;
  localparam int P  = 32;
  localparam int BL = 2;
  localparam int BF = 2;
  localparam int FR = N * P;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] cat;
    logic       fs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] digits;
  logic [3:0]  bmask;
  logic [3:0]  bright;
  logic [3:0]  an;
  logic [7:0]  cat;
  logic        fs;

  logic        rst1;
  logic [5:0]  digits1;
  logic [0:0]  bmask1;
  logic [3:0]  bright1;
  logic [0:0]  an1;
  logic [7:0]  cat1;
  logic        fs1;

  int n_chk = 0;
  int n_fail = 0;
  exp_t q[$];
  bit done1 = 1'b0;

  logic [6:0] seg_tb [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  always #5 clk = ~clk;

  dspl_mux_drv #(
    .N_DIGITS     (N),
    .DIG_PERIOD   (P),
    .BLANK_CYCLES (BL),
    .BLINK_FRAMES (BF)
  ) dut (
    .clock       (clk),
    .reset       (rst),
    .digits      (digits),
    .blink_mask  (bmask),
    .brightness  (bright),
    .an          (an),
    .dec_cat     (cat),
    .frame_start (fs)
  );

  dspl_mux_drv #(
    .N_DIGITS     (1),
    .DIG_PERIOD   (P),
    .BLANK_CYCLES (BL),
    .BLINK_FRAMES (BF)
  ) dut1 (
    .clock       (clk),
    .reset       (rst1),
    .digits      (digits1),
    .blink_mask  (bmask1),
    .brightness  (bright1),
    .an          (an1),
    .dec_cat     (cat1),
    .frame_start (fs1)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [5:0] fld(input bit en,
                                     input logic [3:0] h,
                                     input bit dp);
    return {en, h, dp};
  endfunction

  function automatic logic [5:0] live_fld(input int t);
    int d = (t / P) % N;
    return digits[d*6 +: 6];
  endfunction

  function automatic logic live_blk(input int t);
    int d = (t / P) % N;
    return bmask[d];
  endfunction

  function automatic exp_t model(input int t,
                                 input logic [5:0] f,
                                 input logic blk,
                                 input logic [3:0] br);
    exp_t e;
    int s = t % P;
    int d = (t / P) % N;
    int fr = t / FR;
    bit ph = ((fr / BF) % 2) == 1;
    bit on = f[5] && !(blk && ph) && (s >= BL)
             && ((s % 16) <= int'(br));
    e.an  = 4'hF;
    e.cat = 8'hFF;
    e.fs  = ((t % FR) == 0);
    if (on) begin
      e.an[d] = 1'b0;
      e.cat   = {seg_tb[f[4:1]], ~f[0]};
    end
    return e;
  endfunction

  // Expected-response producer.
  initial begin
    int t_m;
    logic [3:0] brt_m;
    logic [5:0] fld_m;
    logic blk_m;
    t_m = 0;
    brt_m = 4'hF;
    fld_m = '0;
    blk_m = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        t_m = 0;
        brt_m = 4'hF;
        q.push_back('{an: 4'hF, cat: 8'hFF, fs: 1'b0});
      end else begin
        if ((t_m % P) == 0) begin
          fld_m = live_fld(t_m);
          blk_m = live_blk(t_m);
        end
        q.push_back(model(t_m, fld_m, blk_m, brt_m));
        if ((t_m % FR) == FR - 1) brt_m = bright;
        t_m++;
      end
    end
  end

  // Monitor: compares every registered output sample.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        e = q.pop_front();
        chk("sb_out", {19'd0, an, cat, fs},
            {19'd0, e.an, e.cat, e.fs});
      end
    end
  end

  int lo_cnt [4];
  logic [7:0] cat_seen [4];
  int fs_cnt, fs_first, first_dig;

  task automatic run_frame(input int chg_at,
                           input logic [23:0] nd);
    for (int i = 0; i < 4; i++) begin
      lo_cnt[i] = 0;
      cat_seen[i] = 8'h00;
    end
    fs_cnt = 0;
    fs_first = -1;
    first_dig = -1;
    for (int j = 0; j < FR; j++) begin
      @(negedge clk);
      if (j == chg_at) digits = nd;
      if (fs) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = j;
      end
      for (int i = 0; i < 4; i++) begin
        if (an == ~(4'd1 << i)) begin
          lo_cnt[i]++;
          cat_seen[i] = cat;
          if (first_dig < 0) first_dig = i;
        end
      end
    end
  endtask

  int exp_blink [7] = '{30, 0, 0, 30, 30, 0, 0};

  initial begin
    int w;
    rst = 1'b1;
    bmask = 4'b0000;
    bright = 4'hF;
    digits = {fld(1, 4'h0, 0), fld(1, 4'hF, 1),
              fld(1, 4'hA, 0), fld(1, 4'h3, 0)};
    repeat (3) @(negedge clk);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_cat", {24'd0, cat}, 32'hFF);
    chk("rst_fs", {31'd0, fs}, 32'd0);
    rst = 1'b0;

    run_frame(-1, digits);
    chk("f0_fs_cnt", fs_cnt, 1);
    chk("f0_fs_pos", fs_first, 0);
    chk("f0_first_dig", first_dig, 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("f0_lo_d%0d", i), lo_cnt[i], 30);
    chk("f0_cat_d0", {24'd0, cat_seen[0]}, 32'h0D);
    chk("f0_cat_d1", {24'd0, cat_seen[1]}, 32'h11);
    chk("f0_cat_d2", {24'd0, cat_seen[2]}, 32'h70);
    chk("f0_cat_d3", {24'd0, cat_seen[3]}, 32'h03);

    bmask = 4'b0001;
    for (int f = 1; f <= 7; f++) begin
      run_frame(-1, digits);
      chk($sformatf("blink_f%0d_d0", f),
          lo_cnt[0], exp_blink[f-1]);
      chk($sformatf("blink_f%0d_d1", f), lo_cnt[1], 30);
    end

    digits[17:12] = fld(0, 4'hF, 1);
    bright = 4'd3;
    run_frame(-1, digits);
    chk("f8_lo_d0", lo_cnt[0], 30);
    chk("f8_lo_d1", lo_cnt[1], 30);
    chk("f8_lo_d2", lo_cnt[2], 0);
    run_frame(-1, digits);
    chk("f9_lo_d0", lo_cnt[0], 6);
    chk("f9_lo_d2", lo_cnt[2], 0);
    chk("f9_lo_d3", lo_cnt[3], 6);

    run_frame(40, {digits[23:12], fld(1, 4'h5, 0),
                   digits[5:0]});
    chk("f10_lo_d0", lo_cnt[0], 0);
    chk("f10_lo_d1", lo_cnt[1], 6);
    chk("f10_cat_d1", {24'd0, cat_seen[1]}, 32'h11);
    run_frame(-1, digits);
    chk("f11_cat_d1", {24'd0, cat_seen[1]}, 32'h49);
    chk("f11_lo_d3", lo_cnt[3], 6);

    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (an == 4'hF && w < 64);
    chk("mid_lit_seen", {28'd0, an} != 32'hF, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_an", {28'd0, an}, 32'hF);
    chk("mid_rst_cat", {24'd0, cat}, 32'hFF);
    chk("mid_rst_fs", {31'd0, fs}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_frame(-1, digits);
    chk("rr_fs_cnt", fs_cnt, 1);
    chk("rr_fs_pos", fs_first, 0);
    chk("rr_first_dig", first_dig, 0);
    chk("rr_lo_d0", lo_cnt[0], 30);
    chk("rr_lo_d2", lo_cnt[2], 0);
    chk("rr_cat_d1", {24'd0, cat_seen[1]}, 32'h49);

    chk("n1_done", {31'd0, done1}, 32'd1);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

  // Single-digit instance: slot period equals frame.
  initial begin
    int lo1, nfs;
    int fpos [3];
    logic [7:0] c1;
    rst1 = 1'b1;
    digits1 = {1'b1, 4'h5, 1'b1};
    bmask1 = 1'b0;
    bright1 = 4'hF;
    lo1 = 0;
    nfs = 0;
    c1 = 8'h00;
    for (int i = 0; i < 3; i++) fpos[i] = -1;
    repeat (3) @(negedge clk);
    rst1 = 1'b0;
    for (int j = 0; j < 3 * P; j++) begin
      @(negedge clk);
      if (fs1) begin
        if (nfs < 3) fpos[nfs] = j;
        nfs++;
      end
      if (an1 == 1'b0) begin
        lo1++;
        c1 = cat1;
      end
    end
    chk("n1_fs_cnt", nfs, 3);
    chk("n1_fs_pos0", fpos[0], 0);
    chk("n1_fs_pos1", fpos[1], 32);
    chk("n1_fs_pos2", fpos[2], 64);
    chk("n1_lo", lo1, 90);
    chk("n1_cat", {24'd0, c1}, 32'h48);
    done1 = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dspl_mux_drv.md
# dspl_mux_drv

Parametrised, single-clock multiplexed seven-segment display driver for the Nexys A7 display path and any board with up to 16 common-anode digits. It time-multiplexes N_DIGITS hex digits onto one shared cathode bus. Compared with the fixed 8-digit driver it adds full 0–F decode, per-digit blinking, 16-level PWM brightness, anti-ghosting blanking and a frame-start strobe. All logic runs on the system clock through a clock-enable counter; there is no derived clock.

## Interface
Parameters:
- N_DIGITS, 8 – number of multiplexed digits, 1..16
- DIG_PERIOD, 100000 – clock cycles per digit slot (1 ms at 100 MHz); minimum 32
- BLANK_CYCLES, 4 – cycles at slot start with all anodes off; must be < DIG_PERIOD
- BLINK_FRAMES, 250 – frames per blink half-period; minimum 1

Ports:
- clock  in  1  system clock; all state is on the rising edge
- reset  in  1  asynchronous, active-high
- digits  in  6*N_DIGITS  digit i at [6i+5:6i]: bit5 enable, [4:1] hex value, [0] dp on
- blink_mask  in  N_DIGITS  1 = digit blinks
- brightness  in  4  duty level; on-fraction is (brightness+1)/16
- an  out  N_DIGITS  anodes, active-low, registered
- dec_cat  out  8  [7:1] = segments a..g, [0] = dp; active-low, registered
- frame_start  out  1  one-cycle pulse when digit 0's slot begins

## Operation
- slot_cnt counts 0..DIG_PERIOD-1. At the wrap, dig_idx advances by 1 and wraps from N_DIGITS-1 to 0. With N_DIGITS=1, dig_idx stays 0.
- When dig_idx wraps to 0:
  - frame_cnt increments.
  - When frame_cnt reaches BLINK_FRAMES-1 it clears and blink_phase toggles.
  - brightness is latched into bright_q.
- At slot start (slot_cnt==0), the active digit's 6-bit field and blink_mask bit are latched into cur_dig and cur_blink. Input changes mid-slot are not visible until that digit's next slot.
- pwm_cnt is 4 bits, cleared at slot start, and increments every cycle (mod 16).
- Digit on condition: cur_dig[5] & ~(cur_blink & blink_phase) & (slot_cnt >= BLANK_CYCLES) & (pwm_cnt <= bright_q).
- an: only bit dig_idx is low, and only when the digit is on. All bits are 1 otherwise.
- dec_cat[7:1] is the full hex decode of cur_dig[4:1]. Values 0–9 use the existing patterns. A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- dec_cat[0] = ~cur_dig[0].
- dec_cat is 8'hFF whenever an is all-ones.
- Reset (any time, including mid-slot):
  - an all ones, dec_cat=8'hFF, frame_start=0.
  - All counters 0, blink_phase=0, bright_q=4'hF.
  - After release, the first slot is digit 0 and frame_start pulses on the first slot start.

## Timing
- an, dec_cat and frame_start are registered; they reflect the cycle-N state at edge N+1.
- First visible anode in a slot: cycle BLANK_CYCLES+1 after slot start. The last cycle of a slot still drives the previous digit; there is no overlap between digits.
- Full frame = N_DIGITS*DIG_PERIOD cycles. Blink half-period = BLINK_FRAMES frames.
- A brightness change takes effect at the next frame start, never mid-frame.
- frame_start is high for exactly 1 cycle per frame, aligned with digit 0's slot-start cycle.

## Structure
- Shared package dspl_pkg holds:
  - the 16-entry 7-bit segment pattern constant (active-low);
  - DIGIT_W=6 and the field offsets EN_BIT=5, HEX_MSB=4, HEX_LSB=1, DP_BIT=0.
- Sub-module seg7_hex_dec: combinational 4-bit hex plus dp to 8-bit active-low cathode, reading the dspl_pkg constant. It is reusable by other display blocks.
- Top module: slot/PWM/frame counters, digit latch, anode register.
- Sizing: about 180–250 lines total.

## Test plan
Bench parameters: N_DIGITS=4, DIG_PERIOD=32, BLANK_CYCLES=2, BLINK_FRAMES=2.
- **Reset:** assert reset mid-slot → an=4'hF and dec_cat=8'hFF on the same cycle. After release, frame_start pulses once and digit 0 is the first digit lit.
- **Scan order and decode:** digits={en,3,dp0},{en,A},{en,F,dp1},{en,0}, brightness=15 → an cycles 1110, 1101, 1011, 0111, each low for 30 cycles per slot. Cathodes are 0000110_1, 0001000_1, 0111000_0, 0000001_1.
- **Enable and brightness:** clear the enable on digit 2 → slot 2 stays all-high. Set brightness=3 → within each slot an is low for 4 of every 16 pwm cycles after blanking, starting the next frame.
- **Blink:** blink_mask=4'b0001 → digit 0 is dark in frames 2–3 and 6–7 and lit in frames 0–1 and 4–5. Other digits are unaffected.
- **Mid-slot input change:** change digit 1's value mid-slot → the cathode is unchanged until digit 1's next slot. Set N_DIGITS=1 → an[0] is the only anode and frame_start pulses every 32 cycles.
